// File: rtl/fetch_snoopctrl_if.sv
// fetch_snoopctrl_if: snoop requesters, refill control and snoop table bus.
// master = environment side, slave = fetch_snoopctrl side.
interface fetch_snoopctrl_if #(
  parameter int ADDR_W = 32
);
  logic              s0_valid;
  logic [ADDR_W-1:0] s0_addr;
  logic              s0_ready;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_ready;
  logic              rf_start;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_start_ready;
  logic              rf_done;
  logic              flush;
  logic              tbl_wea;
  logic [ADDR_W-1:0] tbl_addra;
  logic              tbl_web;
  logic [ADDR_W-1:0] tbl_q_addr;
  logic              tbl_q_hit;
  logic              rf_replay;
  logic              rf_commit;

  modport master (
    output s0_valid, s0_addr, s1_valid, s1_addr,
    output rf_start, rf_addr, rf_done, flush,
    output tbl_q_hit,
    input  s0_ready, s1_ready, rf_start_ready,
    input  tbl_wea, tbl_addra, tbl_web, tbl_q_addr,
    input  rf_replay, rf_commit
  );

  modport slave (
    input  s0_valid, s0_addr, s1_valid, s1_addr,
    input  rf_start, rf_addr, rf_done, flush,
    input  tbl_q_hit,
    output s0_ready, s1_ready, rf_start_ready,
    output tbl_wea, tbl_addra, tbl_web, tbl_q_addr,
    output rf_replay, rf_commit
  );
endinterface

// File: rtl/fetch_snoopctrl.sv
// fetch_snoopctrl: tracks stores during an I-refill window, votes replay/commit.
// Ports: clk, resetn (async low), bus = fetch_snoopctrl_if.slave.
module fetch_snoopctrl #(
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         resetn,
  fetch_snoopctrl_if.slave bus
);

  if (DEPTH != 6) begin : g_bad_depth
    $error("fetch_snoopctrl: DEPTH must be 6");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CHECK,
    DRAIN
  } state_t;

  localparam logic [2:0] FULL = 3'(DEPTH);

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        cnt_r;
  logic              ovf_r;
  logic              last_r;
  logic [ADDR_W-1:0] qaddr_r;

  logic armed;
  logic full;
  logic gnt0;
  logic gnt1;
  logic accept;
  logic ovf_set;

  // last_r = 1 means s1 was granted last, so s0 wins a tie
  assign armed  = (state_q == ARMED);
  assign full   = (cnt_r == FULL);
  assign gnt0   = armed & bus.s0_valid
                & (~bus.s1_valid | last_r);
  assign gnt1   = armed & bus.s1_valid
                & (~bus.s0_valid | ~last_r);
  assign accept = (state_q == IDLE) & bus.rf_start;

  assign bus.tbl_q_addr = qaddr_r;

  always_comb begin
    state_d            = state_q;
    bus.s0_ready       = 1'b0;
    bus.s1_ready       = 1'b0;
    bus.rf_start_ready = 1'b0;
    bus.tbl_wea        = 1'b0;
    bus.tbl_addra      = '0;
    bus.tbl_web        = 1'b0;
    bus.rf_replay      = 1'b0;
    bus.rf_commit      = 1'b0;
    ovf_set            = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.s0_ready       = 1'b1;
        bus.s1_ready       = 1'b1;
        bus.rf_start_ready = 1'b1;
        if (bus.rf_start) state_d = ARMED;
      end
      ARMED: begin
        bus.s0_ready = gnt0;
        bus.s1_ready = gnt1;
        if (gnt0 | gnt1) begin
          bus.tbl_addra = gnt0 ? bus.s0_addr
                               : bus.s1_addr;
          // a full table still acks the store,
          // but the refill must then replay
          bus.tbl_wea = ~full;
          ovf_set     = full;
        end
        // flush abandons the window, even
        // when refill data lands together
        if (bus.flush) state_d = DRAIN;
        else if (bus.rf_done) state_d = CHECK;
      end
      CHECK: begin
        bus.rf_replay = bus.tbl_q_hit | ovf_r;
        bus.rf_commit = ~(bus.tbl_q_hit | ovf_r);
        state_d       = DRAIN;
      end
      DRAIN: begin
        bus.tbl_web = (cnt_r != 3'd0);
        if (cnt_r == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_r   <= 3'd0;
      ovf_r   <= 1'b0;
      last_r  <= 1'b1;
      qaddr_r <= '0;
    end else begin
      state_q <= state_d;
      if (bus.tbl_wea & ~bus.tbl_web)
        cnt_r <= cnt_r + 3'd1;
      else if (bus.tbl_web & ~bus.tbl_wea)
        cnt_r <= cnt_r - 3'd1;
      if (accept) begin
        qaddr_r <= bus.rf_addr;
        ovf_r   <= 1'b0;
      end else if (ovf_set) begin
        ovf_r <= 1'b1;
      end
      if (gnt0) last_r <= 1'b0;
      else if (gnt1) last_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_snoopctrl.sv
// tb_fetch_snoopctrl: vectors, corner sequences and random vs. reference.
// The snoop table is modelled as a line-granular FIFO queue.
module tb_fetch_snoopctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_snoopctrl_if #(.ADDR_W(32)) bus();

  fetch_snoopctrl #(.DEPTH(6), .ADDR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_CHECK = 2;
  localparam int P_DRAIN = 3;

  int tests = 0;
  int fails = 0;

  int          mph;
  int          mcnt;
  int          mlast;
  bit          movf;
  logic [31:0] mqaddr;

  logic [31:0] tbl[$];
  bit          force_miss;

  logic        a_s0r, a_s1r, a_srr;
  logic        a_wea, a_web, a_rep, a_com;
  logic [31:0] a_addra;

  typedef struct {
    bit s0v;
    bit s1v;
    bit r0;
    bit r1;
    bit wea;
    int cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(string name,
                       logic [70:0] act,
                       logic [70:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic bit lookup(logic [31:0] a);
    foreach (tbl[i])
      if (tbl[i][31:6] == a[31:6]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [70:0] actual();
    return {bus.s0_ready, bus.s1_ready,
            bus.rf_start_ready, bus.tbl_wea,
            bus.tbl_web, bus.rf_replay,
            bus.rf_commit, bus.tbl_addra,
            bus.tbl_q_addr};
  endfunction

  task automatic model_reset();
    mph    = P_IDLE;
    mcnt   = 0;
    movf   = 1'b0;
    mlast  = 1;
    mqaddr = 32'h0;
    tbl.delete();
  endtask

  task automatic model(output logic [70:0] e);
    bit          s0r, s1r, srr, wea, web;
    bit          rep, com;
    logic [31:0] ad;
    logic [31:0] qa;
    int          who;
    int          nph;
    s0r = 0; s1r = 0; srr = 0; wea = 0;
    web = 0; rep = 0; com = 0;
    ad  = 32'h0;
    qa  = mqaddr;
    nph = mph;
    case (mph)
      P_IDLE: begin
        s0r = 1; s1r = 1; srr = 1;
        if (bus.rf_start) begin
          nph    = P_ARMED;
          mqaddr = bus.rf_addr;
          movf   = 1'b0;
        end
      end
      P_ARMED: begin
        who = -1;
        if (bus.s0_valid && bus.s1_valid)
          who = (mlast == 1) ? 0 : 1;
        else if (bus.s0_valid) who = 0;
        else if (bus.s1_valid) who = 1;
        if (who == 0) begin
          s0r = 1; ad = bus.s0_addr;
        end
        if (who == 1) begin
          s1r = 1; ad = bus.s1_addr;
        end
        if (who >= 0) begin
          mlast = who;
          if (mcnt < 6) begin
            wea = 1; mcnt++;
          end else begin
            movf = 1'b1;
          end
        end
        if (bus.flush) nph = P_DRAIN;
        else if (bus.rf_done) nph = P_CHECK;
      end
      P_CHECK: begin
        rep = bus.tbl_q_hit || movf;
        com = !rep;
        nph = P_DRAIN;
      end
      default: begin
        if (mcnt > 0) begin
          web = 1; mcnt--;
        end else begin
          nph = P_IDLE;
        end
      end
    endcase
    mph = nph;
    e = {s0r, s1r, srr, wea, web, rep, com,
         ad, qa};
  endtask

  task automatic step();
    logic [70:0] e;
    bus.tbl_q_hit = !force_miss
                  && lookup(bus.tbl_q_addr);
    #1;
    a_s0r   = bus.s0_ready;
    a_s1r   = bus.s1_ready;
    a_srr   = bus.rf_start_ready;
    a_wea   = bus.tbl_wea;
    a_web   = bus.tbl_web;
    a_rep   = bus.rf_replay;
    a_com   = bus.rf_commit;
    a_addra = bus.tbl_addra;
    model(e);
    check("cycle", actual(), e);
    if (a_web && tbl.size() > 0)
      void'(tbl.pop_front());
    if (a_wea) tbl.push_back(a_addra);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("reset_outputs", actual(),
          {7'b1110000, 64'h0});
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.s0_valid = 0; bus.s0_addr = 0;
    bus.s1_valid = 0; bus.s1_addr = 0;
    bus.rf_start = 0; bus.rf_addr = 0;
    bus.rf_done  = 0; bus.flush   = 0;
  endtask

  task automatic arm(logic [31:0] a);
    bus.rf_start = 1;
    bus.rf_addr  = a;
    step();
    bus.rf_start = 0;
  endtask

  task automatic chk1(string n, logic a, logic x);
    check(n, {70'h0, a}, {70'h0, x});
  endtask

  task automatic chk_int(string n, int a, int x);
    check(n, 71'(a), 71'(x));
  endtask

  logic [31:0] pool[4];
  int          pops;
  int          verd;

  initial begin
    vecs[0] = '{1, 1, 1, 0, 1, 1};
    vecs[1] = '{1, 1, 0, 1, 1, 2};
    vecs[2] = '{1, 1, 1, 0, 1, 3};
    vecs[3] = '{1, 1, 0, 1, 1, 4};
    vecs[4] = '{0, 1, 0, 1, 1, 5};
    vecs[5] = '{0, 0, 0, 0, 0, 5};
    vecs[6] = '{1, 0, 1, 0, 1, 6};
    vecs[7] = '{1, 1, 0, 1, 0, 6};
    pool = '{32'h1000, 32'h1020,
             32'h2000, 32'h3040};

    force_miss = 0;
    bus.tbl_q_hit = 0;
    clear_inputs();
    resetn = 1'b1;
    #2;
    do_reset();

    // replay on a same-line store
    arm(32'h1000);
    bus.s0_valid = 1; bus.s0_addr = 32'h1024;
    step();
    bus.s0_valid = 0; bus.rf_done = 1;
    step();
    bus.rf_done = 0;
    step();
    chk1("hit_replay", a_rep, 1);
    chk1("hit_no_commit", a_com, 0);
    step();
    chk1("hit_pop", a_web, 1);
    step();
    chk1("hit_empty", a_web, 0);
    step();
    chk1("hit_idle", a_srr, 1);

    // commit on an unrelated store
    arm(32'h1000);
    bus.s1_valid = 1; bus.s1_addr = 32'h2000;
    step();
    bus.s1_valid = 0; bus.rf_done = 1;
    step();
    bus.rf_done = 0;
    step();
    chk1("miss_commit", a_com, 1);
    chk1("miss_no_replay", a_rep, 0);
    step();
    chk1("miss_pop", a_web, 1);
    step();
    step();
    chk1("miss_idle", a_srr, 1);

    // arbitration and overflow vectors
    do_reset();
    arm(32'h5000);
    for (int i = 0; i < 8; i++) begin
      bus.s0_valid = vecs[i].s0v;
      bus.s1_valid = vecs[i].s1v;
      bus.s0_addr  = 32'h100 + 32'(i * 4);
      bus.s1_addr  = 32'h200 + 32'(i * 4);
      step();
      check($sformatf("arb_%0d", i),
            {68'h0, a_s0r, a_s1r, a_wea},
            {68'h0, vecs[i].r0, vecs[i].r1,
             vecs[i].wea});
      chk_int($sformatf("cnt_%0d", i),
              tbl.size(), vecs[i].cnt);
    end
    clear_inputs();
    force_miss = 1;
    bus.rf_done = 1;
    step();
    bus.rf_done = 0;
    step();
    chk1("ovf_replay", a_rep, 1);
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      pops += int'(a_web);
    end
    chk_int("ovf_pops", pops, 6);
    step();
    chk1("ovf_idle", a_srr, 1);
    force_miss = 0;

    // flush in ARMED with three entries
    arm(32'h1000);
    bus.s0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.s0_addr = 32'h1000 + 32'(i * 64);
      step();
    end
    bus.s0_valid = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    pops = 0; verd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pops += int'(a_web);
      verd += int'(a_rep) + int'(a_com);
    end
    chk_int("flush_pops", pops, 3);
    chk_int("flush_no_verdict", verd, 0);
    step();
    chk1("flush_idle", a_srr, 1);

    // reset in DRAIN with two entries left
    arm(32'h1000);
    bus.s1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.s1_addr = 32'h7000 + 32'(i * 4);
      step();
    end
    bus.s1_valid = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    step();
    step();
    chk_int("pre_reset_cnt", tbl.size(), 2);
    do_reset();
    step();
    chk1("post_reset_web", a_web, 0);
    chk1("post_reset_ready", a_s0r & a_s1r, 1);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        clear_inputs();
        do_reset();
      end
      bus.s0_valid = 1'($urandom_range(0, 1));
      bus.s1_valid = 1'($urandom_range(0, 1));
      bus.s0_addr  = pool[$urandom_range(0, 3)];
      bus.s1_addr  = pool[$urandom_range(0, 3)];
      bus.rf_addr  = pool[$urandom_range(0, 3)];
      bus.rf_start = ($urandom_range(0, 3) == 0);
      bus.rf_done  = ($urandom_range(0, 5) == 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
